// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: one byte per good frame on data with a single-cycle valid strobe.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity_err.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int SYNC_STAGES = 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  // Synchronizer chain plus a matching "primed" chain that marks when rx_s
  // carries a real line sample rather than its reset value.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic [SYNC_STAGES-1:0] prime_reg;
  logic [SYNC_STAGES-1:0] prime_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi]  = rx;
        assign prime_next[gi] = 1'b1;
      end else begin : g_next
        assign sync_next[gi]  = sync_reg[gi-1];
        assign prime_next[gi] = prime_reg[gi-1];
      end
    end
  endgenerate

  logic rx_s;
  logic line_live;
  assign rx_s      = sync_reg[SYNC_STAGES-1];
  assign line_live = prime_reg[SYNC_STAGES-1];

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_reg, data_next;
  logic            valid_reg, valid_next;
  logic            frame_err_reg, frame_err_next;
  logic            armed_reg, armed_next;
  logic            cnt_last;
  logic            par_bad;

`ifdef UART_RX_PARITY_EN
  logic parity_bit_reg, parity_bit_next;
  logic parity_err_reg, parity_err_next;
  assign par_bad    = ^{shift_reg, parity_bit_reg};
  assign parity_err = parity_err_reg;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign cnt_last  = (cnt_reg == CNT_LAST);
  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg      <= '1;
      prime_reg     <= '0;
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      armed_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      sync_reg      <= sync_next;
      prime_reg     <= prime_next;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      armed_reg     <= armed_next;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= parity_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
    // A start edge only counts once the line has been seen high after reset,
    // so a frame cut by reset is not picked up from its middle.
    armed_next     = armed_reg | (line_live & rx_s);
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit_reg;
    parity_err_next = 1'b0;
`endif

    case (state_reg)
      S_IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
        if (armed_reg && !rx_s) begin
          state_next = S_START;
        end
      end

      S_START: begin
        if (cnt_reg == CNT_MID) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_last) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_last) begin
          cnt_next        = '0;
          parity_bit_next = rx_s;
          state_next      = S_STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (cnt_last) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = S_IDLE;
            if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              parity_err_next = 1'b1;
`endif
            end else begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end
          end else begin
            frame_err_next = 1'b1;
            state_next     = S_BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_BREAK: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: drives UART frames on rx and compares the strobes against
// a frame-level expectation (byte, pulse kind, and the cycle the pulse must appear).
module tb_uart_rx_byte;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int K_VALID  = 1;
  localparam int K_FRAME  = 2;
  localparam int K_PARITY = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int   cyc   = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct {
    int         kind;
    logic [7:0] d;
    int         stamp;
  } ev_t;

  ev_t ev_q[$];
  ev_t exp_q[$];

  int         excl_viol   = 0;
  int         consec_viol = 0;
  int         data_viol   = 0;
  logic       prev_any    = 1'b0;
  logic [7:0] prev_data   = 8'h00;

  // Observer: log every strobe with the cycle it is seen, and track output rules.
  always @(negedge clk) begin
    ev_t ev;
    int  n;
    n = int'(valid === 1'b1) + int'(frame_err === 1'b1) + int'(parity_err === 1'b1);
    if (n > 1) excl_viol++;
    if (n > 0 && prev_any) consec_viol++;
    if (!rst_q && data !== prev_data && valid !== 1'b1) data_viol++;
    if (n > 0) begin
      ev.kind  = (valid === 1'b1) ? K_VALID : (frame_err === 1'b1) ? K_FRAME : K_PARITY;
      ev.d     = data;
      ev.stamp = cyc;
      ev_q.push_back(ev);
    end
    prev_any  = (n > 0);
    prev_data = data;
  end

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame starting at a negedge; the expected outcome comes from the
  // frame content alone. abort_pos >= 0 pulses rst for one cycle mid that bit slot.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_flip, input int abort_pos);
    logic [10:0] bits;
    int          t0;
    ev_t         e;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]   = (^b) ^ par_flip;
    bits[10]  = stop_bit;
`else
    bits[9]   = stop_bit;
`endif
    t0 = cyc;
    for (int k = 0; k < 10 + P; k++) begin
      for (int c = 0; c < CPB; c++) begin
        rx  = bits[k];
        rst = (k == abort_pos) && (c == H);
        @(negedge clk);
      end
    end
    rst = 1'b0;
    rx  = 1'b1;
    if (abort_pos < 0) begin
      e.stamp = t0 + 3 + H + (9 + P) * CPB;
      if (!stop_bit) begin
        e.kind = K_FRAME;
        e.d    = last_good;
      end else if (P == 1 && par_flip) begin
        e.kind = K_PARITY;
        e.d    = last_good;
      end else begin
        e.kind    = K_VALID;
        e.d       = b;
        last_good = b;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drain_check(input string tag);
    ev_t o;
    ev_t e;
    repeat (2) @(negedge clk);
    chk({tag, " count"}, ev_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (ev_q.size() > 0) begin
        o = ev_q.pop_front();
        chk({tag, " kind"},  o.kind,  e.kind);
        chk({tag, " data"},  o.d,     e.d);
        chk({tag, " cycle"}, o.stamp, e.stamp);
      end
    end
    ev_q.delete();
  endtask

  logic [7:0] stream [8] = '{8'h20, 8'h49, 8'h4E, 8'h43, 8'h20, 8'h44, 8'h45, 8'h43};

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset data", data, 8'h00);
    chk("reset valid", valid, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset parity_err", parity_err, 1'b0);
    ev_q.delete();
    idle(1000);
    drain_check("idle");

    send_frame(8'h49, 1'b1, 1'b0, -1);
    idle(2 * CPB);
    drain_check("single");

    foreach (stream[i]) send_frame(stream[i], 1'b1, 1'b0, -1);
    idle(2 * CPB);
    drain_check("stream");

    for (int i = 0; i < 24; i++) begin
      idle($urandom_range(0, 2 * CPB));
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1);
    end
    idle(2 * CPB);
    drain_check("random");

    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    drain_check("glitch");

    send_frame(8'h44, 1'b0, 1'b0, -1);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(3 * CPB);
    chk("frame data held", data, last_good);
    drain_check("frame");

    send_frame(8'h43, 1'b1, 1'b0, -1);
    idle(2 * CPB);
    drain_check("recover");

    // rst lands in data bit 4 (frame slot 5) of 8'h4E.
    send_frame(8'h4E, 1'b1, 1'b0, 5);
    chk("abort data", data, 8'h00);
    chk("abort pulses", ev_q.size(), 0);
    idle(12 * CPB);
    ev_q.delete();
    last_good = data;
    send_frame(8'h45, 1'b1, 1'b0, -1);
    idle(2 * CPB);
    drain_check("after abort");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h49, 1'b1, 1'b0, -1);
    idle(2 * CPB);
    drain_check("parity good");
    send_frame(8'h49, 1'b1, 1'b1, -1);
    idle(2 * CPB);
    drain_check("parity bad");
`endif

    chk("exclusive strobes", excl_viol, 0);
    chk("no consecutive strobes", consec_viol, 0);
    chk("data only with valid", data_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Asynchronous serial receiver that converts an 8N1 UART line into the byte stream consumed by the ASCII command detector. It places one byte on `data` with a single-cycle `valid` strobe per received character. It sits directly upstream of the detector and drives its `data`/`valid` inputs unmodified. Framing errors, and parity errors when parity is compiled in, are flagged and never produce `valid`.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per bit period (100 MHz / 115200). Must be even and ≥ 4.
- `clk`  input  1  clock
- `rst`  input  1  reset, synchronous, active-high
- `rx`  input  1  asynchronous serial line, idle high, LSB first
- `data`  output  8  last received byte; holds until the next good frame
- `valid`  output  1  one-cycle pulse: `data` updated this cycle
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `parity_err`  output  1  one-cycle pulse: parity mismatch. Constant 0 when parity is compiled out.

## Operation
- **Input synchronizer.**
  - `rx` passes through a 2-flop synchronizer, giving `rx_s`.
  - Both flops reset to 1.
- **Counters.**
  - Bit-period counter is `$clog2(CLKS_PER_BIT)` bits wide, counts 0..CLKS_PER_BIT-1, and wraps to 0.
  - Bit index counter is 3 bits.
- **FSM states:** IDLE, START, DATA, PARITY (present only with the macro), STOP, BREAK.
- **IDLE:** on `rx_s`=0, go to START and clear the counter.
- **START:** when the counter reaches CLKS_PER_BIT/2-1, sample `rx_s`.
  - If 1 (glitch), return to IDLE with no output.
  - If 0, go to DATA with the counter and bit index cleared.
- **DATA:** at each counter terminal count (CLKS_PER_BIT-1), shift `rx_s` into the MSB of the shift register (LSB-first reception). After index 7, go to PARITY or STOP.
- **PARITY:** at terminal count, sample the parity bit, then go to STOP.
- **STOP:** at terminal count, sample `rx_s`.
  - If 1 and no parity error: load `data` and pulse `valid`.
  - If 1 with a parity error: pulse `parity_err` only.
  - Either way, go to IDLE.
  - If 0: pulse `frame_err` and go to BREAK.
- **BREAK:** wait for `rx_s`=1, then go to IDLE. A held-low line yields exactly one `frame_err`.
- **Output rules.**
  - `valid`, `frame_err` and `parity_err` are mutually exclusive and never high on consecutive cycles.
  - `data` changes only in the same cycle `valid` is high.
- **Reset values:** state IDLE, `data`=8'h00, `valid`=0, `frame_err`=0, `parity_err`=0, counters 0.

## Timing
- Edge 0 is the first `clk` edge at which the first synchronizer flop captures `rx`=0. Let H = CLKS_PER_BIT/2, P = 1 with parity, 0 without.
  - Start bit sampled at edge 2+H.
  - Data bit k sampled at edge 2+H+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled at edge 2+H+(9+P)·CLKS_PER_BIT.
- Result registers (`data`, `valid`, or an error flag) update on the stop-sample edge and are high for exactly the following cycle.
- **Back-to-back frames:** FSM is in IDLE on the cycle after the stop sample. A start bit beginning at the nominal stop-bit end is received with no loss. Tolerated sender clock mismatch: ±4% (±2% per side).
- **`rst` mid-frame:** the frame is aborted at the next edge. No `valid` or error pulse for that frame; outputs go to reset values. Reception resumes only on a fresh falling edge seen after `rst` deasserts.
- `valid` carries no ready/backpressure. The downstream stage accepts every strobe.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1 (even parity): a parity bit follows D7.
  - The PARITY state exists.
  - `parity_err` pulses when the XOR of D0..D7 and the parity bit is 1. `data`/`valid` are suppressed for that frame.
- Undefined:
  - Frame is 8N1.
  - PARITY state and parity logic are absent.
  - `parity_err` is tied to 0.

## Test plan
- **Reset values:** `rst` high 3 cycles with `rx`=1 → `data`=8'h00, `valid`=`frame_err`=`parity_err`=0; no pulses for 1000 idle cycles.
- **Single byte:** CLKS_PER_BIT=16, send 8'h49 ('I') → `valid` high only in the cycle after edge 154, `data`=8'h49, no error pulse.
- **Back-to-back stream:** send " INC" then " DEC" (8'h20,49,4E,43,20,44,45,43) with no idle gap → exactly 8 `valid` pulses carrying those bytes in order. Feeding them to the detector moves its count 0→1→0.
- **Glitch and framing:**
  - `rx` low for 4 cycles → no output, FSM back in IDLE.
  - Frame with stop bit 0 (byte 8'h44), then line held low for 100 cycles → one `frame_err` pulse, no `valid`, `data` unchanged.
  - Line then returns high and 8'h43 is sent → received normally.
- **Reset mid-frame:** assert `rst` 1 cycle at bit 4 of 8'h4E → no `valid` for that frame. 8'h45 sent afterwards is received correctly.
- **Parity (with `UART_RX_PARITY_EN`):**
  - 8'h49 with parity bit 1 → `valid`, `data`=8'h49.
  - Same frame with parity bit 0 → `parity_err` pulse only, no `valid`.
